frame_bank_ctrl: RTL and testbench
==================================

# frame_bank_ctrl

Parametrised N-bank (triple/quad) frame buffer controller; successor to the double-buffered input buffer between the camera capture path and the CNN window reader. The camera side writes pixels into a free bank. Each frame is validated by pixel count at VSYNC and published as the "latest complete frame". The reader locks the latest bank per frame, so it never sees tearing, and the writer never stalls.

## Interface
- `NUM_BANKS`, 3 — number of frame banks; legal 3..4.
- `ADDR_W`, 17 — pixel address width per bank.
- `FRAME_PIX`, 76800 — pixels per valid frame; must be ≤ 2^ADDR_W.
- `WR_W`, 16 — write pixel width (RGB565).
- `RD_W`, 24 — read pixel width.
- `EXPAND`, 1 — 1: RGB565→RGB888 bit replication on read; 0: pass-through, requires RD_W == WR_W.

Ports:
- `iClk`  in  1  — single system clock; all inputs are already synchronous to it.
- `iRsn`  in  1  — asynchronous, active-low reset.
- `iVsync`  in  1  — camera VSYNC; its rising edge is the frame boundary.
- `iWrEn`  in  1  — pixel write strobe.
- `iWrAddr`  in  ADDR_W  — pixel write address.
- `iWrData`  in  WR_W  — pixel write data.
- `iRdFrameReq`  in  1  — one-cycle pulse at reader frame start; locks the latest bank.
- `iRdEn`  in  1  — read strobe.
- `iRdAddr`  in  ADDR_W  — pixel read address.
- `oRdData`  out  RD_W  — read data, registered.
- `oRdValid`  out  1  — `iRdEn` delayed by one cycle.
- `oFrameAvail`  out  1  — at least one complete frame has been published.
- `oWrBank`  out  2  — current write bank.
- `oRdBank`  out  2  — current locked read bank.
- `oDropCnt`  out  16  — saturating count of discarded frames.

## Operation
- State: `wrBank`, `rdBank`, `rdLocked`, `latestBank`, `latestValid`, `vsyncD`, `pixCnt` (ADDR_W+1 bits, saturating), `dropCnt`.
- Boundary cycle: `iVsync` = 1 and `vsyncD` = 0.
- Writes outside the boundary cycle:
  - If `iWrEn` and `iWrAddr` < FRAME_PIX, write RAM[{wrBank, iWrAddr}] and increment `pixCnt`.
  - Addresses ≥ FRAME_PIX are ignored and not counted.
- Writes in the boundary cycle are discarded and not counted.
- Boundary with `pixCnt` == FRAME_PIX (publish):
  - `latestBank`←`wrBank`, `latestValid`←1.
  - The next `wrBank` is chosen as below.
- Boundary with `pixCnt` ≠ FRAME_PIX (drop):
  - `dropCnt`+1, saturating at 0xFFFF.
  - `wrBank` and `latestBank` are unchanged.
- `pixCnt`←0 on every boundary.
- Lock: `iRdFrameReq` with the post-publish `latestValid` = 1 sets `rdBank`←post-publish `latestBank` and `rdLocked`←1. With `latestValid` = 0 the request is ignored. The lock holds until the next request; re-locking the same bank (frame repeat) is legal.
- Next write bank: the lowest index excluding the next-cycle `latestBank` and, if locked, the next-cycle `rdBank`. With NUM_BANKS ≥ 3 a candidate always exists, so the writer never blocks.
- Simultaneous publish and `iRdFrameReq`: the reader gets the newly published bank in the same cycle, and the write-bank choice excludes it.
- Read: `oRdData` ← expand(RAM[{rdBank, iRdAddr}]) when `iRdEn` and `rdLocked`. When `iRdEn` and not `rdLocked`, `oRdData` ← 0. Otherwise `oRdData` holds.
- Expansion (EXPAND = 1):
  - R = {r5, r5[4:2]}.
  - G = {g6, g6[5:4]}.
  - B = {b5, b5[4:2]}.
- Reset mid-operation clears all state immediately; RAM contents are not cleared, and the first frame after reset is collected from `pixCnt` = 0.

## Timing
- Reset values: `oRdData` = 0, `oRdValid` = 0, `oFrameAvail` = 0, `oWrBank` = 0, `oRdBank` = 0, `oDropCnt` = 0; internally `rdLocked` = 0, `latestValid` = 0, `vsyncD` = 0.
- Read latency: 1 cycle, address to `oRdData`/`oRdValid`. Back-to-back reads run every cycle.
- Write: 1 cycle into RAM. A same-address read/write collision cannot occur by construction (`rdBank` ≠ `wrBank` while locked).
- Boundary effects: `oWrBank`, `oFrameAvail`, `oDropCnt` and `oRdBank` (on lock) update on the clock edge ending the boundary/request cycle.
- `iVsync` held high for multiple cycles gives a single boundary.

## Structure
- Package `fb_pkg`:
  - `BANK_W` = 2.
  - RGB565→RGB888 expansion function.
  - Next-bank selection function (lowest free index).
- Sub-module `fb_sdp_ram`: simple dual-port RAM, WR_W wide, depth NUM_BANKS·2^ADDR_W (the {bank, addr} address wastes the unused bank slot), 1 write port, 1 registered read port. Inferred as BRAM; no reset on the array.
- Top `frame_bank_ctrl`: edge detect, counters, bank FSM/registers, read expansion.

## Test plan
All scenarios use FRAME_PIX = 16, ADDR_W = 5, NUM_BANKS = 3.
1. Reset asserted mid-stream → every output at its reset value asynchronously, and still held there after release until new events arrive.
2. Write 16 pixels (addr 3 = 16'hF800), then a `iVsync` rise → `oFrameAvail` = 1, `oWrBank` = 1. Pulse `iRdFrameReq` → `oRdBank` = 0. Read addr 3 → `oRdData` = 24'hFF0000 one cycle later with `oRdValid` = 1.
3. Write 15 pixels, then a `iVsync` rise → `oDropCnt` = 1, `oWrBank` unchanged, `oFrameAvail` unchanged.
4. Lock bank 0, then publish two frames → `oWrBank` sequence 1→2→1; bank-0 readback is unchanged.
5. `iRdFrameReq` in the same cycle as a publish of bank 2 → `oRdBank` = 2, and the next `oWrBank` ∉ {2}.
6. `iRdEn` before any lock → `oRdData` = 0, `oRdValid` = 1. A write to addr 20 (≥ 16) is ignored, and the frame drops if short.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared types and helpers for the N-bank frame buffer controller.
package fb_pkg;

  localparam int BANK_W = 2;

  typedef logic [BANK_W-1:0] bank_t;

  // Kind of frame boundary seen in the current cycle.
  typedef enum logic [1:0] {
    BND_NONE,
    BND_PUBLISH,
    BND_DROP
  } bnd_e;

  // Bank bookkeeping registers, updated together once per cycle.
  typedef struct packed {
    bank_t wr_bank;
    bank_t rd_bank;
    logic  rd_locked;
    bank_t latest_bank;
    logic  latest_valid;
  } bank_state_t;

  // RGB565 -> RGB888 by replicating the top bits of each channel into the LSBs.
  function automatic logic [23:0] rgb565_to_888(input logic [15:0] p);
    return {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
  endfunction

  // Lowest bank index below num_banks that is neither excl_a nor (if enabled) excl_b.
  function automatic bank_t next_free_bank(input int    num_banks,
                                           input bank_t excl_a,
                                           input logic  excl_b_en,
                                           input bank_t excl_b);
    bank_t pick;
    pick = '0;
    for (int i = (1 << BANK_W) - 1; i >= 0; i--) begin
      if (i < num_banks && bank_t'(i) != excl_a &&
          !(excl_b_en && bank_t'(i) == excl_b)) begin
        pick = bank_t'(i);
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/fb_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port, BRAM-inferable.
module fb_sdp_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 7,
  parameter int DEPTH  = 96
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Synchronous write and registered read of the pixel array.
  // NOTE: the array and its read register carry no reset so they map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/frame_bank_ctrl.sv
// N-bank frame buffer between camera capture and the CNN reader: tear-free, writer never stalls.
module frame_bank_ctrl
  import fb_pkg::*;
#(
  parameter int NUM_BANKS = 3,      // legal 3..4
  parameter int ADDR_W    = 17,
  parameter int FRAME_PIX = 76800,  // must be <= 2**ADDR_W
  parameter int WR_W      = 16,
  parameter int RD_W      = 24,
  parameter int EXPAND    = 1       // 0 requires RD_W == WR_W
) (
  input  logic              iClk,
  input  logic              iRsn,
  input  logic              iVsync,
  input  logic              iWrEn,
  input  logic [ADDR_W-1:0] iWrAddr,
  input  logic [WR_W-1:0]   iWrData,
  input  logic              iRdFrameReq,
  input  logic              iRdEn,
  input  logic [ADDR_W-1:0] iRdAddr,
  output logic [RD_W-1:0]   oRdData,
  output logic              oRdValid,
  output logic              oFrameAvail,
  output logic [1:0]        oWrBank,
  output logic [1:0]        oRdBank,
  output logic [15:0]       oDropCnt
);

  localparam int CNT_W  = ADDR_W + 1;
  localparam int RAM_AW = BANK_W + ADDR_W;
  localparam int DEPTH  = NUM_BANKS << ADDR_W;
  localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_PIX);

  logic              vsync_d;
  logic [CNT_W-1:0]  pix_cnt;
  logic [15:0]       drop_cnt;
  bank_state_t       st, st_nxt;
  bnd_e              bnd;
  logic              boundary;
  logic              wr_accept;
  logic              ram_rd_en;
  logic [WR_W-1:0]   ram_q;
  logic [RD_W-1:0]   rd_pix;
  logic              rd_zero;
  logic              rd_valid;

  assign boundary  = iVsync && !vsync_d;
  assign wr_accept = iWrEn && !boundary && ({1'b0, iWrAddr} < FRAME_CNT);
  assign ram_rd_en = iRdEn && st.rd_locked;

  // Classify the boundary, publish, lock, and pick the next free write bank.
  // NOTE: every output gets a default first so no path leaves one unassigned (no latch);
  // blocking '=' is used here so later lines see the updated st_nxt fields.
  always_comb begin
    st_nxt = st;
    bnd    = BND_NONE;
    if (boundary) bnd = (pix_cnt == FRAME_CNT) ? BND_PUBLISH : BND_DROP;
    if (bnd == BND_PUBLISH) begin
      st_nxt.latest_bank  = st.wr_bank;
      st_nxt.latest_valid = 1'b1;
    end
    // The reader sees a frame published in this same cycle.
    if (iRdFrameReq && st_nxt.latest_valid) begin
      st_nxt.rd_bank   = st_nxt.latest_bank;
      st_nxt.rd_locked = 1'b1;
    end
    if (bnd == BND_PUBLISH) begin
      st_nxt.wr_bank = next_free_bank(NUM_BANKS, st_nxt.latest_bank,
                                      st_nxt.rd_locked, st_nxt.rd_bank);
    end
  end

  // Bank bookkeeping register.
  // NOTE: sequential state uses non-blocking '<=' so all flops update from pre-edge values.
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) st <= '0;
    else       st <= st_nxt;
  end

  // VSYNC edge detect, saturating pixel counter and saturating drop counter.
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      vsync_d  <= 1'b0;
      pix_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      vsync_d <= iVsync;
      if (boundary)                        pix_cnt <= '0;
      else if (wr_accept && pix_cnt != '1) pix_cnt <= pix_cnt + 1'b1;
      if (bnd == BND_DROP && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 1'b1;
    end
  end

  // Read-side control: valid strobe and "no lock yet" zero flag, aligned with the RAM read.
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      rd_valid <= 1'b0;
      rd_zero  <= 1'b1;
    end else begin
      rd_valid <= iRdEn;
      if (iRdEn) rd_zero <= !st.rd_locked;
    end
  end

  fb_sdp_ram #(
    .DATA_W (WR_W),
    .ADDR_W (RAM_AW),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (iClk),
    .wr_en   (wr_accept),
    .wr_addr ({st.wr_bank, iWrAddr}),
    .wr_data (iWrData),
    .rd_en   (ram_rd_en),
    .rd_addr ({st.rd_bank, iRdAddr}),
    .rd_data (ram_q)
  );

  if (EXPAND != 0) begin : g_expand
    assign rd_pix = RD_W'(rgb565_to_888(16'(ram_q)));
  end else begin : g_pass
    assign rd_pix = RD_W'(ram_q);
  end

  assign oRdData     = rd_zero ? '0 : rd_pix;
  assign oRdValid    = rd_valid;
  assign oFrameAvail = st.latest_valid;
  assign oWrBank     = st.wr_bank;
  assign oRdBank     = st.rd_bank;
  assign oDropCnt    = drop_cnt;

endmodule

// File: tb/tb_frame_bank_ctrl.sv
// Self-checking bench for frame_bank_ctrl (3 banks, 16-pixel frames).
module tb_frame_bank_ctrl;

  localparam int AW = 5;
  localparam int FP = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          vsync = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [15:0]   wr_data = '0;
  logic          rd_req = 1'b0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [23:0]   rd_data;
  logic          rd_valid;
  logic          frame_avail;
  logic [1:0]    wr_bank;
  logic [1:0]    rd_bank;
  logic [15:0]   drop_cnt;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [23:0] sb [$];
  logic [23:0] sb_exp;
  logic [15:0] frame_buf [FP];

  typedef struct {
    logic [AW-1:0] addr;
    logic [15:0]   pix;
    logic [23:0]   exp;
  } vec_t;
  vec_t vecs [8];

  frame_bank_ctrl #(
    .NUM_BANKS (3), .ADDR_W (AW), .FRAME_PIX (FP),
    .WR_W (16), .RD_W (24), .EXPAND (1)
  ) dut (
    .iClk        (clk),
    .iRsn        (rst_n),
    .iVsync      (vsync),
    .iWrEn       (wr_en),
    .iWrAddr     (wr_addr),
    .iWrData     (wr_data),
    .iRdFrameReq (rd_req),
    .iRdEn       (rd_en),
    .iRdAddr     (rd_addr),
    .oRdData     (rd_data),
    .oRdValid    (rd_valid),
    .oFrameAvail (frame_avail),
    .oWrBank     (wr_bank),
    .oRdBank     (rd_bank),
    .oDropCnt    (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_pix(input int a, input logic [15:0] d);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic fill_frame(input logic [15:0] d);
    for (int i = 0; i < FP; i++) frame_buf[i] = d;
  endtask

  task automatic write_frame(input int n);
    for (int i = 0; i < n; i++) write_pix(i, frame_buf[i]);
  endtask

  task automatic vsync_pulse(input logic req);
    vsync  = 1'b1;
    rd_req = req;
    tick();
    rd_req = 1'b0;
    vsync  = 1'b0;
    tick();
  endtask

  task automatic lock_req();
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
  endtask

  // Issue one read and queue its expected data; rd_en is left high for back-to-back use.
  task automatic rd(input int a, input logic [23:0] e);
    rd_en   = 1'b1;
    rd_addr = AW'(a);
    sb.push_back(e);
    tick();
  endtask

  task automatic check_outputs(input string tag, input logic avail, input logic [1:0] wb,
                               input logic [1:0] rb, input logic [15:0] drops);
    check({tag, "_avail"}, 32'(frame_avail), 32'(avail));
    check({tag, "_wr_bank"}, 32'(wr_bank), 32'(wb));
    check({tag, "_rd_bank"}, 32'(rd_bank), 32'(rb));
    check({tag, "_drop_cnt"}, 32'(drop_cnt), 32'(drops));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rd_data"}, 32'(rd_data), 32'h0);
    check({tag, "_rd_valid"}, 32'(rd_valid), 32'h0);
    check_outputs(tag, 1'b0, 2'd0, 2'd0, 16'd0);
  endtask

  // Scoreboard: every valid read pops the oldest expected value.
  always @(negedge clk) begin
    if (rst_n && rd_valid) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_underflow: read data %0h with no expected entry", rd_data);
      end else begin
        sb_exp = sb.pop_front();
        check("rd_data", 32'(rd_data), 32'(sb_exp));
      end
    end
  end

  initial begin
    vecs[0] = '{5'd0, 16'h07E0, 24'h00FF00};
    vecs[1] = '{5'd1, 16'h001F, 24'h0000FF};
    vecs[2] = '{5'd2, 16'hFFFF, 24'hFFFFFF};
    vecs[3] = '{5'd3, 16'hF800, 24'hFF0000};
    vecs[4] = '{5'd4, 16'h0000, 24'h000000};
    vecs[5] = '{5'd5, 16'h8410, 24'h848284};
    vecs[6] = '{5'd6, 16'h0821, 24'h080408};
    vecs[7] = '{5'd7, 16'hA554, 24'hA5AAA5};

    // Power-on reset.
    repeat (3) @(posedge clk);
    #2;
    check_reset_vals("por_in_reset");
    rst_n = 1'b1;
    tick();
    check_reset_vals("por_released");

    // Reads and lock requests before any frame is published.
    rd(3, 24'h0);
    check("unlocked_rd_valid", 32'(rd_valid), 32'h1);
    rd_en = 1'b0;
    lock_req();
    check("lock_ignored_rd_bank", 32'(rd_bank), 32'h0);
    rd(3, 24'h0);
    rd_en = 1'b0;
    // 15 in-range pixels plus an out-of-range write: still a short frame.
    fill_frame(16'h1111);
    write_frame(FP - 1);
    write_pix(20, 16'h2222);
    vsync_pulse(1'b0);
    check_outputs("short_oob", 1'b0, 2'd0, 2'd0, 16'd1);

    // Full frame into bank 0, publish, lock, back-to-back table reads.
    fill_frame(16'h0000);
    foreach (vecs[v]) frame_buf[vecs[v].addr] = vecs[v].pix;
    write_frame(FP);
    vsync_pulse(1'b0);
    check_outputs("publish0", 1'b1, 2'd1, 2'd0, 16'd1);
    lock_req();
    check("lock0_rd_bank", 32'(rd_bank), 32'h0);
    foreach (vecs[v]) rd(int'(vecs[v].addr), vecs[v].exp);
    check("b2b_rd_valid_hi", 32'(rd_valid), 32'h1);
    rd_en = 1'b0;
    tick();
    check("b2b_rd_valid_lo", 32'(rd_valid), 32'h0);

    // Short frame, VSYNC held 3 cycles with a write in the boundary cycle: one drop.
    fill_frame(16'h3333);
    write_frame(FP - 1);
    wr_en   = 1'b1;
    wr_addr = AW'(15);
    wr_data = 16'h3333;
    vsync   = 1'b1;
    tick();
    wr_en = 1'b0;
    tick();
    tick();
    vsync = 1'b0;
    tick();
    check_outputs("drop_long_vsync", 1'b1, 2'd1, 2'd0, 16'd2);

    // Bank 0 locked: two publishes rotate the writer 1 -> 2 -> 1.
    fill_frame(16'h001F);
    write_frame(FP);
    vsync_pulse(1'b0);
    check("rot_wr_bank_a", 32'(wr_bank), 32'h2);
    fill_frame(16'hFFFF);
    write_frame(FP);
    vsync_pulse(1'b0);
    check_outputs("rot_b", 1'b1, 2'd1, 2'd0, 16'd2);
    rd(3, 24'hFF0000);
    rd(0, 24'h00FF00);
    rd_en = 1'b0;

    // Publish bank 1 to move the writer to bank 2, then publish bank 2 with a lock.
    fill_frame(16'h0821);
    write_frame(FP);
    vsync_pulse(1'b0);
    check("pre_sim_wr_bank", 32'(wr_bank), 32'h2);
    fill_frame(16'h07E0);
    write_frame(FP);
    vsync_pulse(1'b1);
    check_outputs("sim_lock", 1'b1, 2'd0, 2'd2, 16'd2);
    rd(5, 24'h00FF00);
    rd_en = 1'b0;
    fill_frame(16'h8410);
    write_frame(FP);
    vsync_pulse(1'b0);
    check_outputs("after_sim", 1'b1, 2'd1, 2'd2, 16'd2);

    // Mid-stream asynchronous reset with a partial frame in progress.
    fill_frame(16'hF800);
    write_frame(5);
    rd(5, 24'h00FF00);
    #5;
    rst_n = 1'b0;
    rd_en = 1'b0;
    #1;
    check_reset_vals("mid_reset_async");
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    tick();
    tick();
    check_reset_vals("mid_reset_released");
    // First frame after reset counts from zero.
    write_frame(FP);
    vsync_pulse(1'b0);
    check_outputs("post_reset_publish", 1'b1, 2'd1, 2'd0, 16'd0);
    lock_req();
    rd(3, 24'hFF0000);
    rd_en = 1'b0;
    tick();

    check("sb_empty", 32'(sb.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
